// File: rtl/fetch_pkg.sv
// Shared fetch-front-end definitions: default PC parameters, branch-select
// encodings used by the branch controller, and the buffered fetch entry type.
package fetch_pkg;

  localparam int ADDR_W_DEFAULT  = 32;
  localparam int INSTR_W_DEFAULT = 32;

  localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W_DEFAULT-1:0] PC_STEP_DEFAULT  = 32'd4;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_JUMP = 2'b01;
  localparam logic [1:0] BR_ZERO = 2'b10;
  localparam logic [1:0] BR_NEG  = 2'b11;

  typedef struct packed {
    logic [INSTR_W_DEFAULT-1:0] instr;
    logic [ADDR_W_DEFAULT-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {instr, pc} entries.
// Flush (and reset) take priority over push and pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output entry_t     head_o,
  output logic [1:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  entry_t     mem [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  assign do_pop  = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, fixed one-cycle imem request/response
// tracking, and a 2-entry output buffer with valid/ready toward IF/ID.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_W_DEFAULT,
  parameter int                    INSTR_WIDTH = INSTR_W_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(PC_STEP_DEFAULT)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pc_select_i,
  input  logic                   clear_pipes_i,
  input  logic [ADDR_WIDTH-1:0]  branch_target_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   instr_ready_i
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;

  entry_t     head;
  entry_t     push_data;
  logic [1:0] buf_count;
  logic       buf_full;
  logic       buf_empty;
  logic       pop;
  logic       room;
  logic       issue;

  assign instr_valid_o = !buf_empty & !rst_i;
  assign pop           = instr_valid_o & instr_ready_i;

  // Buffered plus in-flight entries may not exceed two once this cycle's pop retires.
  assign room  = pop | !(buf_full | ((buf_count == 2'd1) & inflight_q));
  assign issue = !rst_i & !pc_select_i & !clear_pipes_i & room;

  assign imem_req_o  = issue;
  assign imem_addr_o = issue ? pc_q : '0;
  assign instr_o     = instr_valid_o ? head.instr : '0;
  assign instr_pc_o  = instr_valid_o ? head.pc : '0;

  // Stage p0: request issue and PC advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      if (pc_select_i)  pc_q <= branch_target_i;
      else if (issue)   pc_q <= pc_q + PC_STEP;
      inflight_q <= issue;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) inflight_pc_q <= pc_q;
  end

  // Stage p1: memory response tagged with its PC enters the buffer
  assign push_data = '{instr: imem_rdata_i, pc: inflight_pc_q};

  fetch_buffer #(
    .entry_t (entry_t)
  ) u_buffer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (clear_pipes_i),
    .head_o      (head),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based fetch model checked every cycle,
// plus hand-computed expectations for reset, stall, redirect and mid-run reset.
module tb_fetch_unit;

  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        pc_select_i;
  logic        clear_pipes_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = 32'hDEAD_BEEF;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  fetch_unit dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .pc_select_i     (pc_select_i),
    .clear_pipes_i   (clear_pipes_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ifn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Fixed-latency memory: data for the address requested in the previous cycle.
  always @(posedge clk) imem_rdata_i <= imem_req_o ? ifn(imem_addr_o) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event logs (cycle, value) gathered from the DUT
  int          req_cyc[$];
  logic [31:0] req_addr[$];
  int          pres_cyc[$];
  logic [31:0] pres_pc[$];
  int          dlv_cyc[$];
  logic [31:0] dlv_pc[$];

  function automatic logic [63:0] req_at(input int c);
    foreach (req_cyc[i]) if (req_cyc[i] == c) return {32'h0, req_addr[i]};
    return NONE;
  endfunction

  function automatic logic [63:0] pres_at(input int c);
    foreach (pres_cyc[i]) if (pres_cyc[i] == c) return {32'h0, pres_pc[i]};
    return NONE;
  endfunction

  function automatic logic [63:0] dlv_at(input int c);
    foreach (dlv_cyc[i]) if (dlv_cyc[i] == c) return {32'h0, dlv_pc[i]};
    return NONE;
  endfunction

  // Behavioural model: next PC, one pending memory reply, queue of buffered PCs.
  logic [31:0] m_pc = 32'h0;
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [31:0] m_q[$];
  bit          exp_valid, exp_req, hs;
  logic [31:0] exp_pc;
  int          occ;
  bit          hold_q = 1'b0;
  logic [31:0] held_pc, held_instr;

  always @(negedge clk) begin
    exp_valid = !rst_i && (m_q.size() > 0);
    exp_pc    = exp_valid ? m_q[0] : 32'h0;
    hs        = exp_valid && instr_ready_i;
    occ       = m_q.size() + (m_infl ? 1 : 0) - (hs ? 1 : 0);
    exp_req   = !rst_i && !pc_select_i && !clear_pipes_i && (occ < 2);

    check("imem_req", {63'h0, imem_req_o}, {63'h0, exp_req});
    if (exp_req || rst_i) check("imem_addr", imem_addr_o, exp_req ? m_pc : 32'h0);
    check("instr_valid", {63'h0, instr_valid_o}, {63'h0, exp_valid});
    if (exp_valid || rst_i) begin
      check("instr_pc", instr_pc_o, exp_pc);
      check("instr", instr_o, exp_valid ? ifn(exp_pc) : 32'h0);
    end
    if (hold_q && !rst_i) begin
      check("hold_valid", {63'h0, instr_valid_o}, 64'h1);
      check("hold_pc", instr_pc_o, held_pc);
      check("hold_instr", instr_o, held_instr);
    end
    hold_q     = instr_valid_o && !instr_ready_i && !clear_pipes_i && !rst_i;
    held_pc    = instr_pc_o;
    held_instr = instr_o;
    if (clear_pipes_i && !pc_select_i && !rst_i)
      $display("note: protocol violation, clear_pipes_i without pc_select_i @cyc %0d", cyc);

    if (imem_req_o) begin req_cyc.push_back(cyc); req_addr.push_back(imem_addr_o); end
    if (instr_valid_o) begin pres_cyc.push_back(cyc); pres_pc.push_back(instr_pc_o); end
    if (instr_valid_o && instr_ready_i && !clear_pipes_i && !rst_i) begin
      dlv_cyc.push_back(cyc); dlv_pc.push_back(instr_pc_o);
    end

    if (rst_i) begin
      m_pc = 32'h0;
      m_infl = 1'b0;
      m_q.delete();
    end else begin
      if (clear_pipes_i) m_q.delete();
      else begin
        if (hs) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
      end
      m_infl_pc = m_pc;
      if (pc_select_i) m_pc = branch_target_i;
      else if (exp_req) m_pc = m_pc + 32'd4;
      m_infl = exp_req;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"},   {63'h0, imem_req_o},    64'h0);
    check({tag, "_valid"}, {63'h0, instr_valid_o}, 64'h0);
    check({tag, "_addr"},  imem_addr_o, 64'h0);
    check({tag, "_instr"}, instr_o,     64'h0);
    check({tag, "_pc"},    instr_pc_o,  64'h0);
  endtask

  int t0, r, s, x, y, z;
  logic [31:0] tq[$];
  logic [31:0] want;
  int n10, n14, n80, r80;

  initial begin
    rst_i = 1'b1; pc_select_i = 1'b0; clear_pipes_i = 1'b0;
    branch_target_i = 32'h0; instr_ready_i = 1'b1;
    tick(); tick();
    @(negedge clk);
    check_outputs_zero("reset");
    tick();
    rst_i = 1'b0; t0 = cyc;

    repeat (4) tick();
    r = cyc; pc_select_i = 1'b1; clear_pipes_i = 1'b1; branch_target_i = 32'h40;
    tick();
    pc_select_i = 1'b0; clear_pipes_i = 1'b0;
    repeat (5) tick();

    s = cyc; instr_ready_i = 1'b0;
    repeat (5) tick();
    instr_ready_i = 1'b1;
    repeat (4) tick();

    x = cyc; instr_ready_i = 1'b0; pc_select_i = 1'b1; clear_pipes_i = 1'b1;
    branch_target_i = 32'h100;
    tick();
    instr_ready_i = 1'b1; pc_select_i = 1'b0; clear_pipes_i = 1'b0;
    repeat (4) tick();

    y = cyc; pc_select_i = 1'b1; clear_pipes_i = 1'b1; branch_target_i = 32'h80;
    tick();
    branch_target_i = 32'hC0;
    tick();
    pc_select_i = 1'b0; clear_pipes_i = 1'b0;
    repeat (5) tick();

    z = cyc; rst_i = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst0");
    tick();
    @(negedge clk);
    check_outputs_zero("midrst1");
    tick();
    rst_i = 1'b0;
    repeat (5) tick();
    @(negedge clk);

    check("seq_req0", req_at(t0),     64'h0);
    check("seq_req1", req_at(t0 + 1), 64'h4);
    check("seq_req2", req_at(t0 + 2), 64'h8);
    check("seq_pc0",  pres_at(t0 + 2), 64'h0);
    check("seq_pc1",  pres_at(t0 + 3), 64'h4);
    check("seq_pc2",  pres_at(t0 + 4), 64'h8);

    check("redir_noreq",  req_at(r),      NONE);
    check("redir_req",    req_at(r + 1),  64'h40);
    check("redir_gap1",   pres_at(r + 1), NONE);
    check("redir_gap2",   pres_at(r + 2), NONE);
    check("redir_first",  pres_at(r + 3), 64'h40);

    for (int i = 1; i <= 4; i++) check("stall_noreq", req_at(s + i), NONE);
    check("stall_head",   pres_at(s + 4), 64'h4C);
    check("stall_resume", req_at(s + 5),  64'h54);
    check("stall_dlv",    dlv_at(s + 5),  64'h4C);

    check("full_noreq", req_at(x),      NONE);
    check("full_req",   req_at(x + 1),  64'h100);
    check("full_gap1",  pres_at(x + 1), NONE);
    check("full_gap2",  pres_at(x + 2), NONE);
    check("full_first", pres_at(x + 3), 64'h100);

    check("b2b_noreq0", req_at(y),      NONE);
    check("b2b_noreq1", req_at(y + 1),  NONE);
    check("b2b_req",    req_at(y + 2),  64'hC0);
    check("b2b_gap",    pres_at(y + 3), NONE);
    check("b2b_first",  pres_at(y + 4), 64'hC0);

    check("rst_req",   req_at(z + 2),  64'h0);
    check("rst_gap1",  pres_at(z + 2), NONE);
    check("rst_gap2",  pres_at(z + 3), NONE);
    check("rst_first", pres_at(z + 4), 64'h0);

    n10 = 0; n14 = 0; n80 = 0; r80 = 0;
    foreach (dlv_pc[i]) begin
      if (dlv_pc[i] == 32'h10) n10++;
      if (dlv_pc[i] == 32'h14) n14++;
      if (dlv_pc[i] == 32'h80) n80++;
    end
    foreach (req_addr[i]) if (req_addr[i] == 32'h80) r80++;
    check("no_dlv_10",  n10, 0);
    check("no_dlv_14",  n14, 0);
    check("no_dlv_80",  n80, 0);
    check("no_fetch_80", r80, 0);

    // Delivered PCs must run in +4 steps, jumping only to each redirect target in turn.
    tq = '{32'h40, 32'h100, 32'hC0, 32'h0};
    if (dlv_pc.size() == 0) check("dlv_any", 64'h0, 64'h1);
    else begin
      check("dlv_first", dlv_pc[0], 64'h0);
      for (int i = 1; i < dlv_pc.size(); i++) begin
        if (tq.size() > 0 && dlv_pc[i] == tq[0] && dlv_pc[i] != dlv_pc[i-1] + 32'd4) begin
          want = tq[0];
          void'(tq.pop_front());
        end else want = dlv_pc[i-1] + 32'd4;
        check("dlv_seq", dlv_pc[i], want);
      end
    end
    check("targets_reached", tq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
